// File: rtl/std_clock_gate_ctrl.sv
// std_clock_gate_ctrl: multi-channel clock gate controller; each channel wakes on request,
// settles for WAKE_CYCLES, reports ready, and gates itself after IDLE_CYCLES of inactivity.
module std_clock_gate_ctrl #(
    parameter logic [31:0] CLOCK_INFO  = '0,
    parameter int          TECHNOLOGY  = 0,  // 0: simulation/ASIC latch gate, 1: Xilinx BUFGCE_1
    parameter int          CHANNELS    = 4,
    parameter int          WAKE_CYCLES = 2,
    parameter int          IDLE_CYCLES = 8,
    parameter bit          RESET_ON    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic [CHANNELS-1:0] force_on,
    input  logic                bypass,
    output logic [CHANNELS-1:0] ready,
    output logic [CHANNELS-1:0] clk_en,
    output logic [CHANNELS-1:0] clk_out
);
    localparam int MAXC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

    typedef enum logic [1:0] {OFF, WAKE, ON} state_t;
    localparam state_t RST_STATE = RESET_ON ? ON : OFF;

    logic unused_info;
    assign unused_info = ^CLOCK_INFO;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          en_q, rdy_q, want, en_eff, en_lat;

        assign want = req[c] | force_on[c];

        // one counter serves both the settle countdown and the idle count-up
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                OFF: if (want) begin
                    state_d = WAKE;
                    cnt_d   = CW'(WAKE_CYCLES - 1);
                end
                WAKE: if (cnt_q == '0) begin
                    state_d = ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
                ON: if (want) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(IDLE_CYCLES)) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                default: begin
                    state_d = RST_STATE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= RST_STATE;
                cnt_q   <= '0;
                en_q    <= RESET_ON;
                rdy_q   <= RESET_ON;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                en_q    <= state_d != OFF;
                rdy_q   <= state_d == ON;
            end
        end

        assign ready[c]  = rdy_q;
        assign clk_en[c] = en_q;
        assign en_eff    = en_q | bypass;

        // enable only moves while clk is low, so every gated pulse is full width
        always_latch begin
            if (!clk) en_lat <= en_eff;
        end

        if (TECHNOLOGY == 1) begin : g_xil
`ifdef STD_XILINX
            BUFGCE_1 u_bufg (.I(clk), .CE(en_eff), .O(clk_out[c]));
`else
            assign clk_out[c] = clk & en_lat;
`endif
        end else begin : g_sim
            assign clk_out[c] = clk & en_lat;
        end
    end
endmodule

// File: doc/std_clock_gate_ctrl.md
Name: std_clock_gate_ctrl

Overview:
- Parametrised multi-channel clock-gating controller. Next generation of the single-enable std_clock_gate.
- Each channel runs a small state machine: wake on request, wait a settle interval, report ready, then auto-gate after a programmable idle interval.
- Gating of each output clock is glitch-free. Gate primitive is chosen by technology (BUFGCE_1 on Xilinx, latch-and-AND in simulation/ASIC).
- Sits between the root clock and per-unit clock domains; power-management logic or the units themselves drive the requests.

Parameters:
- CLOCK_INFO, 'b0, std_clock_info_t passed through for timing metadata; no functional effect.
- TECHNOLOGY, STD_TECHNOLOGY_SIMULATION, selects gate primitive.
- CHANNELS, 4, number of independently gated clock outputs (>=1).
- WAKE_CYCLES, 2, cycles the gate is open before ready asserts (>=1).
- IDLE_CYCLES, 8, consecutive cycles with req low in ON before gating (>=0).
- RESET_ON, 0, 1: all channels leave reset in ON with ready=1; 0: reset to OFF.

Ports:
- clk  input  1  root clock; also the source for every clk_out.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  CHANNELS  per-channel activity request, level.
- force_on  input  CHANNELS  holds the channel in ON and blocks the idle countdown.
- bypass  input  1  global: all clk_out follow clk ungated; FSMs keep running.
- ready  output  CHANNELS  channel clock is running and settled.
- clk_en  output  CHANNELS  registered internal gate enable, for observation.
- clk_out  output  CHANNELS  gated clocks.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values, RESET_ON=0: all FSMs OFF, clk_en=0, ready=0, counters=0, clk_out low.
- Reset values, RESET_ON=1: all FSMs ON, clk_en=1, ready=1.
- Asserting rst_n mid-operation returns every channel to its reset state immediately, including mid-WAKE.
- Channel wants-on term: want = req | force_on.
- OFF: if want, go to WAKE next edge, clk_en=1, wake counter loaded with WAKE_CYCLES-1. Otherwise stay in OFF.
- WAKE: clk_en=1, ready=0.
  - Counter decrements each cycle; at 0, go to ON with ready=1.
  - Dropping want during WAKE does not abort: the channel completes WAKE, enters ON, then idles normally.
- ON: clk_en=1, ready=1.
  - If want=0, the idle counter increments; any cycle with want=1 clears it.
  - When the counter reaches IDLE_CYCLES with want=0, go to OFF next edge, with clk_en=0 and ready=0 on that same edge.
  - IDLE_CYCLES=0: the channel goes OFF on the first edge that samples want=0.
  - If want reasserts on the same edge the count completes, want wins and the channel stays ON.
- Latency, req rising in OFF to ready: WAKE_CYCLES+1 edges.
- Latency, last want cycle to clk_en falling: IDLE_CYCLES+1 edges.
- Gate, simulation/ASIC: clk_en is captured by a transparent-low latch per channel; clk_out = clk & latch. Pulses are always full-width and never glitch, including when clk_en changes during clk high.
- Gate, Xilinx: BUFGCE_1 per channel, with CE driven by clk_en (or 1 under bypass).
- bypass: effective enable = clk_en | bypass. ready and clk_en are unaffected.
- Counter widths: $clog2(max(WAKE_CYCLES, IDLE_CYCLES)+1), minimum 1 bit. No counter wraps; counters saturate or reload per state.
- Channel independence: channels share no state. Simultaneous events on different channels are handled independently.
- Output timing: all outputs are registered (clk_out is latch+gate only), with no combinational path from req to ready.

Test Plan:
- Reset, RESET_ON=0, CH=4, req=0: ready=0, clk_en=0, clk_out flat. Then req[0]=1 at edge 0 (WAKE=2) -> clk_en[0]=1 after edge 1, ready[0]=1 after edge 3; other channels stay off.
- Idle timeout, IDLE=4, channel ON: drop req[1] -> ready[1]/clk_en[1] fall on the 5th edge. A glitch of req[1]=1 for one cycle at count 3 -> counter restarts, and the fall occurs 5 edges after that cycle.
- force_on[2]=1 with req[2]=0 for 100 cycles -> channel 2 ON throughout. Release force_on -> OFF after IDLE+1 edges.
- Toggle clk_en mid-high phase via async timing in sim -> every clk_out pulse equals the full clk high width; no runt pulses (checked by pulse-width assertion).
- bypass=1 with all channels OFF -> all clk_out toggle with clk while ready=0. Deassert bypass -> clk_out returns low on the next low phase.
- rst_n asserted mid-WAKE on channel 3 -> immediate clk_en[3]=0, ready[3]=0. On release with req[3] held high, a full WAKE sequence repeats. RESET_ON=1 variant: ready=all-ones right after reset release.
